switches_debounced: RTL and testbench

Parametrised, clocked successor to the bussed switch input peripheral. Supports N_BANKS banks of 8 switches, with per-bit input synchronisation, counter-based debounce and optional polarity inversion. Keeps sticky per-bit change flags that are cleared by write-1-to-clear, and raises an interrupt when any flag is set. Sits on the shared 8-bit address/data/control bus; ce comes from the address decoder.

---
 rtl/switches_debounced_if.sv | 12 +
 rtl/switches_debounced.sv | 99 +++++++++
 tb/tb_switches_debounced.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/switches_debounced_if.sv
// Shared peripheral bus control signals: chip enable, direction and address.
// The 8-bit data line stays a plain inout on the peripheral so it can tri-state.
interface switches_debounced_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              ce;
  logic              rw;
  logic [ADDR_W-1:0] addr;

  modport master (output ce, output rw, output addr);
  modport slave  (input  ce, input  rw, input  addr);
endinterface

// File: rtl/switches_debounced.sv
// Banked switch input peripheral: per-bit synchroniser, counter debounce,
// sticky W1C change flags with interrupt, on the shared 8-bit bus.
module switches_debounced #(
  parameter int unsigned N_BANKS         = 2,
  parameter int unsigned ADDR_W          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned INVERT          = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  switches_debounced_if.slave  bus,
  inout  wire  [7:0]           data,
  input  logic [8*N_BANKS-1:0] in_sw,
  output logic                 irq
);

  localparam int unsigned NB    = 8 * N_BANKS;
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic        INV_BIT  = (INVERT != 0);

  logic [NB-1:0]    sync1_q, sync2_q;
  logic [NB-1:0]    deb_q, deb_d;
  logic [NB-1:0]    flag_q, flag_d;
  logic [NB-1:0]    set_c, clr_c;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];
  logic [7:0]       rdata_c;
  logic             wr_en_c;
  logic             rd_en_c;

  assign wr_en_c = bus.ce & ~bus.rw;
  assign rd_en_c = bus.ce &  bus.rw;

  // Per-bit debounce: D consecutive mismatching samples are needed to accept a new level
  always_comb begin
    deb_d = deb_q;
    set_c = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
        set_c[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // W1C on the flag registers; a coincident set takes priority
  always_comb begin
    clr_c = '0;
    for (int unsigned k = 0; k < N_BANKS; k++) begin
      if (wr_en_c && (bus.addr == ADDR_W'(N_BANKS + k))) begin
        clr_c[8*k +: 8] = data;
      end
    end
    flag_d = (flag_q & ~clr_c) | set_c;
  end

  always_comb begin
    rdata_c = 8'h00;
    for (int unsigned k = 0; k < N_BANKS; k++) begin
      if (bus.addr == ADDR_W'(k)) begin
        rdata_c = deb_q[8*k +: 8];
      end
      if (bus.addr == ADDR_W'(N_BANKS + k)) begin
        rdata_c = flag_q[8*k +: 8];
      end
    end
  end

  assign data = rd_en_c ? rdata_c : 8'bz;
  assign irq  = |flag_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      flag_q  <= '0;
      for (int unsigned i = 0; i < NB; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= in_sw ^ {NB{INV_BIT}};
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      flag_q  <= flag_d;
      for (int unsigned i = 0; i < NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_switches_debounced.sv
// Randomised scoreboard bench for switches_debounced with a sliding-window debounce model.
module tb_switches_debounced;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned NB = 8 * N;

  typedef struct {
    logic [7:0] d;
    logic       irq;
    logic       has_dir;
    logic [7:0] dir_d;
    logic       dir_irq;
    string      name;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NB-1:0] in_sw = '1;
  logic          irq;
  logic          drv_en = 1'b0;
  logic [7:0]    drv_val = 8'h00;
  logic          probe = 1'b0;
  wire  [7:0]    data;

  int n_chk = 0;
  int n_err = 0;
  exp_t sb_q[$];

  switches_debounced_if #(.ADDR_W(AW)) bus ();

  assign data = drv_en ? drv_val : 8'bz;

  switches_debounced #(
    .N_BANKS(N), .ADDR_W(AW), .DEBOUNCE_CYCLES(D), .INVERT(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .data(data), .in_sw(in_sw), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last D doubly-delayed samples all disagree with it
  logic [NB-1:0] m_z1, m_z2, m_deb, m_flag;
  logic [NB-1:0] m_hist [D];
  int            m_hcnt;

  always @(posedge clk or negedge reset_n) begin : model
    logic [NB-1:0] nset;
    logic [NB-1:0] clr;
    logic          all_diff;
    if (!reset_n) begin
      m_z1 <= '0; m_z2 <= '0; m_deb <= '0; m_flag <= '0; m_hcnt <= 0;
      for (int j = 0; j < D; j++) m_hist[j] <= '0;
    end else begin
      nset = '0;
      for (int i = 0; i < NB; i++) begin
        all_diff = (m_hcnt >= D - 1) && (m_z2[i] != m_deb[i]);
        for (int j = 0; j < D - 1; j++) if (m_hist[j][i] == m_deb[i]) all_diff = 1'b0;
        nset[i] = all_diff;
      end
      clr = '0;
      if (bus.ce && !bus.rw && bus.addr >= AW'(N) && bus.addr < AW'(2 * N))
        clr[8 * (int'(bus.addr) - N) +: 8] = drv_val;
      m_deb  <= m_deb ^ nset;
      m_flag <= (m_flag & ~clr) | nset;
      m_hist[0] <= m_z2;
      for (int j = 1; j < D; j++) m_hist[j] <= m_hist[j-1];
      m_hcnt <= (m_hcnt < D) ? m_hcnt + 1 : m_hcnt;
      m_z2 <= m_z1;
      m_z1 <= ~in_sw;
    end
  end

  function automatic logic [7:0] m_read(int a);
    if (a < N)     return m_deb[8*a +: 8];
    if (a < 2 * N) return m_flag[8*(a-N) +: 8];
    return 8'h00;
  endfunction

  // Monitor: every presented read (or undriven-bus probe) pops and compares one item
  always @(negedge clk) begin
    exp_t e;
    if ((bus.ce && bus.rw) || probe) begin
      if (sb_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL scoreboard_empty: read at %0t with no expectation", $time);
      end else begin
        e = sb_q.pop_front();
        n_chk++;
        if (data !== e.d || irq !== e.irq) begin
          n_err++;
          $display("FAIL model_cmp addr=%0d: got data=%h irq=%b expected data=%h irq=%b at %0t",
                   bus.addr, data, irq, e.d, e.irq, $time);
        end
        if (e.has_dir) begin
          n_chk++;
          if (data !== e.dir_d || irq !== e.dir_irq) begin
            n_err++;
            $display("FAIL %s: got data=%h irq=%b expected data=%h irq=%b",
                     e.name, data, irq, e.dir_d, e.dir_irq);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(logic has_dir, logic [7:0] dd, logic di, string nm, logic [7:0] md);
    exp_t e;
    e.d = md; e.irq = |m_flag;
    e.has_dir = has_dir; e.dir_d = dd; e.dir_irq = di; e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic rd(int a);
    bus.ce = 1'b1; bus.rw = 1'b1; bus.addr = AW'(a); drv_en = 1'b0; probe = 1'b0;
    push_exp(1'b0, 8'h00, 1'b0, "", m_read(a));
    step();
  endtask

  task automatic rd_chk(int a, logic [7:0] exp_d, logic exp_irq, string nm);
    bus.ce = 1'b1; bus.rw = 1'b1; bus.addr = AW'(a); drv_en = 1'b0; probe = 1'b0;
    push_exp(1'b1, exp_d, exp_irq, nm, m_read(a));
    step();
  endtask

  task automatic wr(int a, logic [7:0] d);
    bus.ce = 1'b1; bus.rw = 1'b0; bus.addr = AW'(a); drv_en = 1'b1; drv_val = d; probe = 1'b0;
    step();
  endtask

  task automatic probe_z();
    bus.ce = 1'b0; bus.rw = 1'b1; bus.addr = AW'($urandom_range(0, 7));
    drv_en = 1'b1; drv_val = 8'h5A; probe = 1'b1;
    push_exp(1'b0, 8'h00, 1'b0, "", 8'h5A);
    step();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) rd($urandom_range(0, 7));
  endtask

  initial begin
    bus.ce = 1'b0; bus.rw = 1'b1; bus.addr = '0;
    step(); step(); step();
    rd_chk(0, 8'h00, 1'b0, "reset_addr0");
    rd_chk(2, 8'h00, 1'b0, "reset_addr2");
    reset_n = 1'b1;
    ticks(20);
    rd_chk(0, 8'h00, 1'b0, "idle_addr0");
    rd_chk(2, 8'h00, 1'b0, "idle_addr2");
    probe_z();

    // Clean press of bit0: visible at the 6th edge, not the 5th
    in_sw[7:0] = 8'hFE;
    ticks(5);
    rd_chk(0, 8'h00, 1'b0, "press_edge5");
    rd_chk(0, 8'h01, 1'b1, "press_edge6");
    rd_chk(2, 8'h01, 1'b1, "press_flag");

    // 3-cycle glitch on bit8 must be rejected
    in_sw[8] = 1'b0;
    ticks(3);
    in_sw[8] = 1'b1;
    ticks(8);
    rd_chk(1, 8'h00, 1'b1, "glitch_val");
    rd_chk(3, 8'h00, 1'b1, "glitch_flag");

    // W1C behaviour
    in_sw[7:0] = 8'hFA;
    ticks(8);
    rd_chk(2, 8'h05, 1'b1, "w1c_start");
    wr(2, 8'h04);
    rd_chk(2, 8'h01, 1'b1, "w1c_bit2");
    wr(2, 8'h01);
    rd_chk(2, 8'h00, 1'b0, "w1c_bit0");
    wr(0, 8'hFF);
    wr(5, 8'hFF);
    rd_chk(0, 8'h05, 1'b0, "ro_value");
    rd_chk(2, 8'h00, 1'b0, "ignored_wr");

    // Clear lands on the same edge that sets the flag: set wins
    in_sw[7:0] = 8'hFB;
    ticks(5);
    wr(2, 8'h01);
    rd_chk(2, 8'h01, 1'b1, "collision");
    rd_chk(0, 8'h04, 1'b1, "collision_val");
    wr(2, 8'hFF);

    // Reset mid-debounce, then the still-held input re-qualifies from scratch
    in_sw[15:8] = 8'hFE;
    ticks(2);
    reset_n = 1'b0;
    rd_chk(1, 8'h00, 1'b0, "in_reset_val");
    rd_chk(0, 8'h00, 1'b0, "in_reset_val0");
    reset_n = 1'b1;
    ticks(4);
    rd_chk(3, 8'h00, 1'b0, "post_rst_e4");
    rd_chk(1, 8'h00, 1'b0, "post_rst_e5");
    rd_chk(1, 8'h01, 1'b1, "post_rst_e6");
    rd_chk(3, 8'h01, 1'b1, "post_rst_flag");
    rd_chk(7, 8'h00, 1'b1, "oob_addr7");

    // Randomised traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) in_sw = in_sw ^ (NB'(1) << $urandom_range(0, NB - 1));
      case ($urandom_range(0, 9))
        0, 1:    wr($urandom_range(0, 7), 8'($urandom));
        2:       probe_z();
        default: rd($urandom_range(0, 7));
      endcase
    end
    bus.ce = 1'b0; drv_en = 1'b0; probe = 1'b0;
    step(); step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
